// File: rtl/l2_line_store.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_store
// Description : One L2 way's storage: metadata array, byte-enabled line array
//               and memory-return line buffer, all with registered reads.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_line_store #(
    parameter int S_OFFSET   = 5,
    parameter int S_INDEX    = 3,
    parameter int META_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    // metadata array
    input  logic                          meta_read,
    input  logic                          meta_load,
    input  logic [S_INDEX-1:0]            meta_rindex,
    input  logic [S_INDEX-1:0]            meta_windex,
    input  logic [META_WIDTH-1:0]         meta_datain,
    output logic [META_WIDTH-1:0]         meta_dataout,
    // line data array
    input  logic                          data_read,
    input  logic [(2**S_OFFSET)-1:0]      data_write_en,
    input  logic [S_INDEX-1:0]            data_rindex,
    input  logic [S_INDEX-1:0]            data_windex,
    input  logic [(8*(2**S_OFFSET))-1:0]  data_datain,
    output logic [(8*(2**S_OFFSET))-1:0]  data_dataout,
    // memory read buffer
    input  logic                          buf_load,
    input  logic [(8*(2**S_OFFSET))-1:0]  buf_in,
    output logic [(8*(2**S_OFFSET))-1:0]  buf_out
);

    localparam int c_mask     = 2**S_OFFSET;
    localparam int c_line     = 8*c_mask;
    localparam int c_num_sets = 2**S_INDEX;

    // ------------------------------------------------------------------
    // Metadata array with write-through forwarding on the read port
    // ------------------------------------------------------------------
    logic [META_WIDTH-1:0] r_meta_mem [c_num_sets];
    logic [META_WIDTH-1:0] r_meta_dataout;
    logic                  w_meta_fwd;

    assign w_meta_fwd = meta_load && (meta_rindex == meta_windex);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < c_num_sets; s++) begin
                r_meta_mem[s] <= '0;
            end
            r_meta_dataout <= '0;
        end else begin
            if (meta_load) begin
                r_meta_mem[meta_windex] <= meta_datain;
            end
            if (meta_read) begin
                r_meta_dataout <= w_meta_fwd ? meta_datain : r_meta_mem[meta_rindex];
            end
        end
    end

    assign meta_dataout = r_meta_dataout;

    // ------------------------------------------------------------------
    // Line array, stored as independent byte lanes so forwarding and
    // write masking are naturally per byte.
    // ------------------------------------------------------------------
    logic w_data_same_set;

    assign w_data_same_set = (data_rindex == data_windex);

    generate
        for (genvar i = 0; i < c_mask; i++) begin : g_byte
            logic [7:0] r_lane [c_num_sets];
            logic [7:0] r_lane_out;
            logic [7:0] w_lane_in;
            logic       w_lane_fwd;

            assign w_lane_in  = data_datain[8*i +: 8];
            assign w_lane_fwd = data_write_en[i] && w_data_same_set;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < c_num_sets; s++) begin
                        r_lane[s] <= 8'h00;
                    end
                    r_lane_out <= 8'h00;
                end else begin
                    if (data_write_en[i]) begin
                        r_lane[data_windex] <= w_lane_in;
                    end
                    if (data_read) begin
                        r_lane_out <= w_lane_fwd ? w_lane_in : r_lane[data_rindex];
                    end
                end
            end

            assign data_dataout[8*i +: 8] = r_lane_out;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Memory read buffer
    // ------------------------------------------------------------------
    logic [c_line-1:0] r_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
        end else if (buf_load) begin
            r_buf <= buf_in;
        end
    end

    assign buf_out = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_l2_line_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_line_store
// Description : Directed self-checking bench for l2_line_store (24-bit meta).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_line_store;

    logic          clk;
    logic          rst;
    logic          meta_read;
    logic          meta_load;
    logic [2:0]    meta_rindex;
    logic [2:0]    meta_windex;
    logic [23:0]   meta_datain;
    logic [23:0]   meta_dataout;
    logic          data_read;
    logic [31:0]   data_write_en;
    logic [2:0]    data_rindex;
    logic [2:0]    data_windex;
    logic [255:0]  data_datain;
    logic [255:0]  data_dataout;
    logic          buf_load;
    logic [255:0]  buf_in;
    logic [255:0]  buf_out;

    int tests_run;
    int tests_failed;

    l2_line_store #(
        .S_OFFSET   (5),
        .S_INDEX    (3),
        .META_WIDTH (24)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .meta_read     (meta_read),
        .meta_load     (meta_load),
        .meta_rindex   (meta_rindex),
        .meta_windex   (meta_windex),
        .meta_datain   (meta_datain),
        .meta_dataout  (meta_dataout),
        .data_read     (data_read),
        .data_write_en (data_write_en),
        .data_rindex   (data_rindex),
        .data_windex   (data_windex),
        .data_datain   (data_datain),
        .data_dataout  (data_dataout),
        .buf_load      (buf_load),
        .buf_in        (buf_in),
        .buf_out       (buf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        meta_read     = 1'b0;
        meta_load     = 1'b0;
        meta_rindex   = '0;
        meta_windex   = '0;
        meta_datain   = '0;
        data_read     = 1'b0;
        data_write_en = '0;
        data_rindex   = '0;
        data_windex   = '0;
        data_datain   = '0;
        buf_load      = 1'b0;
        buf_in        = '0;
    endtask

    task automatic test_reset();
        #10;
        tests_run++;
        if (meta_dataout !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_meta: got %h expected %h", meta_dataout, 24'h0);
        end
        tests_run++;
        if (data_dataout !== 256'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected %h", data_dataout, 256'h0);
        end
        tests_run++;
        if (buf_out !== 256'h0) begin
            tests_failed++;
            $display("FAIL reset_buf: got %h expected %h", buf_out, 256'h0);
        end
        rst = 1'b1;
        // all three sub-blocks active in one cycle
        meta_load = 1'b1; meta_windex = 3'd5; meta_datain = 24'hABCDEF;
        meta_read = 1'b1; meta_rindex = 3'd5;
        data_write_en = 32'hFFFF_FFFF; data_windex = 3'd5; data_datain = {32{8'hA5}};
        data_read = 1'b1; data_rindex = 3'd5;
        buf_load = 1'b1; buf_in = {32{8'h5A}};
        tick();
        idle_inputs();
        tests_run++;
        if (meta_dataout !== 24'hABCDEF) begin
            tests_failed++;
            $display("FAIL concurrent_meta: got %h expected %h", meta_dataout, 24'hABCDEF);
        end
        tests_run++;
        if (data_dataout !== {32{8'hA5}}) begin
            tests_failed++;
            $display("FAIL concurrent_data: got %h expected %h", data_dataout, {32{8'hA5}});
        end
        tests_run++;
        if (buf_out !== {32{8'h5A}}) begin
            tests_failed++;
            $display("FAIL concurrent_buf: got %h expected %h", buf_out, {32{8'h5A}});
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (meta_dataout !== 24'h0) begin
            tests_failed++;
            $display("FAIL async_reset_meta: got %h expected %h", meta_dataout, 24'h0);
        end
        tests_run++;
        if (buf_out !== 256'h0 || data_dataout !== 256'h0) begin
            tests_failed++;
            $display("FAIL async_reset_data_buf: got %h / %h expected 0", data_dataout, buf_out);
        end
        // write presented during reset must be discarded
        meta_load = 1'b1; meta_windex = 3'd5; meta_datain = 24'h000055;
        tick();
        idle_inputs();
        #2;
        rst = 1'b1;
        meta_read = 1'b1; meta_rindex = 3'd5;
        data_read = 1'b1; data_rindex = 3'd5;
        tick();
        idle_inputs();
        tests_run++;
        if (meta_dataout !== 24'h0) begin
            tests_failed++;
            $display("FAIL post_reset_meta5: got %h expected %h", meta_dataout, 24'h0);
        end
        tests_run++;
        if (data_dataout !== 256'h0) begin
            tests_failed++;
            $display("FAIL post_reset_data5: got %h expected %h", data_dataout, 256'h0);
        end
    endtask

    task automatic test_meta_write_read();
        meta_load = 1'b1; meta_windex = 3'd3; meta_datain = 24'h123456;
        tick();
        idle_inputs();
        meta_read = 1'b1; meta_rindex = 3'd3;
        tick();
        tests_run++;
        if (meta_dataout !== 24'h123456) begin
            tests_failed++;
            $display("FAIL meta_read_set3: got %h expected %h", meta_dataout, 24'h123456);
        end
        meta_rindex = 3'd2;
        tick();
        idle_inputs();
        tests_run++;
        if (meta_dataout !== 24'h0) begin
            tests_failed++;
            $display("FAIL meta_read_set2: got %h expected %h", meta_dataout, 24'h0);
        end
    endtask

    task automatic test_meta_forward();
        meta_load = 1'b1; meta_windex = 3'd7; meta_datain = 24'h000001;
        meta_read = 1'b1; meta_rindex = 3'd7;
        tick();
        tests_run++;
        if (meta_dataout !== 24'h000001) begin
            tests_failed++;
            $display("FAIL meta_forward_same: got %h expected %h", meta_dataout, 24'h000001);
        end
        meta_rindex = 3'd6;
        tick();
        idle_inputs();
        tests_run++;
        if (meta_dataout !== 24'h0) begin
            tests_failed++;
            $display("FAIL meta_forward_other: got %h expected %h", meta_dataout, 24'h0);
        end
        meta_read = 1'b1; meta_rindex = 3'd7;
        tick();
        idle_inputs();
        tests_run++;
        if (meta_dataout !== 24'h000001) begin
            tests_failed++;
            $display("FAIL meta_set7_kept: got %h expected %h", meta_dataout, 24'h000001);
        end
        // read port holds while a write lands on the last-read set
        meta_load = 1'b1; meta_windex = 3'd7; meta_datain = 24'h000042;
        meta_rindex = 3'd7;
        tick();
        idle_inputs();
        tests_run++;
        if (meta_dataout !== 24'h000001) begin
            tests_failed++;
            $display("FAIL meta_hold: got %h expected %h", meta_dataout, 24'h000001);
        end
        meta_read = 1'b1; meta_rindex = 3'd7;
        tick();
        idle_inputs();
        tests_run++;
        if (meta_dataout !== 24'h000042) begin
            tests_failed++;
            $display("FAIL meta_set7_new: got %h expected %h", meta_dataout, 24'h000042);
        end
    endtask

    task automatic test_byte_mask();
        logic [255:0] exp;
        data_write_en = 32'hFFFF_FFFF; data_windex = 3'd1; data_datain = {32{8'h11}};
        tick();
        data_write_en = 32'h0000_000F; data_datain = {32{8'hFF}};
        tick();
        idle_inputs();
        data_read = 1'b1; data_rindex = 3'd1;
        tick();
        idle_inputs();
        exp = {{28{8'h11}}, {4{8'hFF}}};
        tests_run++;
        if (data_dataout !== exp) begin
            tests_failed++;
            $display("FAIL byte_mask_set1: got %h expected %h", data_dataout, exp);
        end
        // read set 1 while fully writing set 0: read returns old set 1 contents
        data_read = 1'b1; data_rindex = 3'd1;
        data_write_en = 32'hFFFF_FFFF; data_windex = 3'd0; data_datain = {32{8'h77}};
        tick();
        idle_inputs();
        tests_run++;
        if (data_dataout !== exp) begin
            tests_failed++;
            $display("FAIL diff_index_read: got %h expected %h", data_dataout, exp);
        end
        data_read = 1'b1; data_rindex = 3'd0;
        tick();
        idle_inputs();
        tests_run++;
        if (data_dataout !== {32{8'h77}}) begin
            tests_failed++;
            $display("FAIL diff_index_write: got %h expected %h", data_dataout, {32{8'h77}});
        end
    endtask

    task automatic test_byte_forward();
        logic [255:0] exp;
        data_write_en = 32'hFFFF_FFFF; data_windex = 3'd4; data_datain = {32{8'h22}};
        tick();
        data_write_en = 32'h8000_0000; data_datain = {32{8'h33}};
        data_read = 1'b1; data_rindex = 3'd4;
        tick();
        idle_inputs();
        exp = {8'h33, {31{8'h22}}};
        tests_run++;
        if (data_dataout !== exp) begin
            tests_failed++;
            $display("FAIL byte_forward: got %h expected %h", data_dataout, exp);
        end
        data_read = 1'b1; data_rindex = 3'd2;
        tick();
        data_rindex = 3'd4;
        tick();
        idle_inputs();
        tests_run++;
        if (data_dataout !== exp) begin
            tests_failed++;
            $display("FAIL byte_forward_stored: got %h expected %h", data_dataout, exp);
        end
    endtask

    task automatic test_buffer_hold();
        logic [255:0] exp;
        logic [255:0] held;
        exp = {8{32'hDEADBEEF}};
        buf_load = 1'b1; buf_in = exp;
        tick();
        tests_run++;
        if (buf_out !== exp) begin
            tests_failed++;
            $display("FAIL buf_load: got %h expected %h", buf_out, exp);
        end
        buf_load = 1'b0; buf_in = {8{32'h0BADF00D}};
        tick();
        tick();
        tests_run++;
        if (buf_out !== exp) begin
            tests_failed++;
            $display("FAIL buf_hold: got %h expected %h", buf_out, exp);
        end
        idle_inputs();
        // data_dataout was last loaded from set 4 in test_byte_forward
        held = {8'h33, {31{8'h22}}};
        data_write_en = 32'hFFFF_FFFF; data_windex = 3'd4; data_datain = {32{8'h44}};
        data_rindex = 3'd4;
        tick();
        idle_inputs();
        tests_run++;
        if (data_dataout !== held) begin
            tests_failed++;
            $display("FAIL data_hold: got %h expected %h", data_dataout, held);
        end
        data_read = 1'b1; data_rindex = 3'd4;
        tick();
        idle_inputs();
        tests_run++;
        if (data_dataout !== {32{8'h44}}) begin
            tests_failed++;
            $display("FAIL data_after_hold: got %h expected %h", data_dataout, {32{8'h44}});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        idle_inputs();
        #2;
        rst = 1'b0;
        test_reset();
        test_meta_write_read();
        test_meta_forward();
        test_byte_mask();
        test_byte_forward();
        test_buffer_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l2_line_store.md
Name: l2_line_store

Overview:
- Storage primitives for one way of the L2 cache, bundled in one block:
  - a per-set metadata array (valid/dirty/tag/LRU style);
  - a 256-bit cache-line data array with per-byte write enables;
  - a line-wide buffer register that captures memory read data.
- Sits under the L2 cache datapath; the datapath instantiates one per way and drives index, enable and data lines from the cache controller.
- All reads are registered; one-cycle read latency.

Parameters:
- s_offset, 5, byte-offset bits; s_mask = 2**s_offset bytes per line (32).
- s_index, 3, set-index bits; num_sets = 2**s_index (8).
- s_line, 8*2**s_offset, line width in bits (256).
- meta_width, 1, width of each metadata entry (1 for valid/dirty, 24 for tag, 3 for LRU).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- meta_read  in  1  update meta_dataout on the next edge.
- meta_load  in  1  write meta_datain to entry meta_windex.
- meta_rindex  in  s_index  metadata read set.
- meta_windex  in  s_index  metadata write set.
- meta_datain  in  meta_width  metadata write value.
- meta_dataout  out  meta_width  registered metadata read value.
- data_read  in  1  update data_dataout on the next edge.
- data_write_en  in  s_mask  per-byte write enable; bit i covers bits [8i+7:8i].
- data_rindex  in  s_index  line read set.
- data_windex  in  s_index  line write set.
- data_datain  in  s_line  line write value.
- data_dataout  out  s_line  registered line read value.
- buf_load  in  1  capture buf_in.
- buf_in  in  s_line  line from physical memory.
- buf_out  out  s_line  buffered line.

Behaviour:
- Reset:
  - rst low immediately (asynchronously) clears all metadata entries, all data-array lines, meta_dataout, data_dataout and buf_out to 0.
  - Everything holds at 0 while rst is low; writes and loads presented during reset are discarded.
  - Normal operation resumes at the first rising edge after rst goes high.
- Metadata array, per rising edge:
  - If meta_load: mem[meta_windex] <= meta_datain.
  - If meta_read: meta_dataout <= (meta_load && meta_rindex==meta_windex) ? meta_datain : mem[meta_rindex]. This is write-through forwarding, so a same-cycle read of the written set returns the new value.
  - If !meta_read: meta_dataout holds its previous value, even if the addressed entry is written.
- Data array, per rising edge:
  - For each byte i with data_write_en[i]=1: mem[data_windex] byte i <= data_datain byte i. Other bytes are unchanged.
  - All-zero enable is a no-write; all-ones enable writes the full line.
  - If data_read: data_dataout byte i <= (data_write_en[i] && data_rindex==data_windex) ? data_datain byte i : mem[data_rindex] byte i. Forwarding is per byte; unwritten bytes come from stored data.
  - If !data_read: data_dataout holds.
- Buffer register: if buf_load, buf_out <= buf_in on the edge; otherwise it holds.
- Latency and ordering:
  - Read latency is exactly one cycle from index presentation to dataout; there is no handshake.
  - The three sub-blocks are independent and may all operate in the same cycle.
  - Different read and write indices in the same cycle: the read returns the old contents of rindex and the write still commits.
- Index range is the full 0..num_sets-1; no wrap or out-of-range case exists.

Test Plan:
- Reset:
  - Write meta_width=24 entry 5 = 0xABCDEF; assert rst low mid-cycle.
  - -> meta_dataout = 0 immediately.
  - After release, reading set 5 -> 0.
- Metadata write then read:
  - Load set 3 = 0x123456; next cycle read set 3.
  - -> meta_dataout = 0x123456 one edge later.
  - Set 2 still reads 0.
- Same-cycle forwarding:
  - Load set 7 = 1 with meta_read=1, rindex=windex=7.
  - -> meta_dataout = 1 after that same edge.
  - With rindex=6 instead -> 0 returned, and set 7 still holds 1.
- Byte-masked line write:
  - Fill set 1 with all 0x11 (write_en = all ones).
  - Then write data_datain bytes = 0xFF with write_en = 0x0000_000F.
  - -> reading set 1 returns low 4 bytes 0xFF and the remaining 28 bytes 0x11.
- Per-byte forwarding:
  - Set 4 holds 0x22 bytes; write 0x33 bytes with write_en = 0x8000_0000 while reading set 4.
  - -> data_dataout byte 31 = 0x33, bytes 0..30 = 0x22.
- Buffer and hold:
  - buf_load=1 with buf_in = 256'hDEAD...; then buf_load=0 with buf_in changed.
  - -> buf_out keeps the first value.
  - With data_read=0 and a write to the read set -> data_dataout unchanged.
